// File: rtl/wb_soc_pkg.sv
// Shared definitions for the SoC Wishbone register-bus initiator.
//   wb_status_t    : response status code returned on the response port
//   wb_mst_state_t : initiator FSM states
//   WB_*_W         : bus field widths
//   cnt_width()    : counter width able to hold 0..max_val (never narrower than 1 bit)
package wb_soc_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        WB_OK  = 2'b00,
        WB_ERR = 2'b01,
        WB_RTY = 2'b10,
        WB_TMO = 2'b11
    } wb_status_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BACKOFF,
        RESP
    } wb_mst_state_t;

    // A limit of 0 would give a zero-width counter; keep at least one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_soc_master_if.sv
// Bundle of the command port, response port, busy flag and Wishbone classic
// bus signals of the SoC register-bus initiator.
//   master modport : view of the initiator (drives cmd_ready, rsp_*, busy, p_wb_*_O)
//   slave  modport : view of the surrounding logic (drives cmd_*, rsp_ready, p_wb_*_I)
interface wb_soc_master_if;
    import wb_soc_pkg::*;

    // command port
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [WB_ADR_W-1:0] cmd_adr;
    logic [WB_DAT_W-1:0] cmd_dat;
    logic [WB_SEL_W-1:0] cmd_sel;
    logic                cmd_lock;

    // response port
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WB_DAT_W-1:0] rsp_dat;
    wb_status_t          rsp_status;

    logic                busy;

    // Wishbone classic bus
    logic [WB_ADR_W-1:0] p_wb_ADR_O;
    logic [WB_DAT_W-1:0] p_wb_DAT_O;
    logic [WB_DAT_W-1:0] p_wb_DAT_I;
    logic [WB_SEL_W-1:0] p_wb_SEL_O;
    logic                p_wb_CYC_O;
    logic                p_wb_STB_O;
    logic                p_wb_WE_O;
    logic                p_wb_LOCK_O;
    logic                p_wb_ACK_I;
    logic                p_wb_ERR_I;
    logic                p_wb_RTY_I;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_lock,
        input  rsp_ready,
        input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I,
        output cmd_ready, rsp_valid, rsp_dat, rsp_status, busy,
        output p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O,
        output p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_lock,
        output rsp_ready,
        output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_status, busy,
        input  p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O,
        input  p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O
    );

endinterface

// File: rtl/wb_soc_master.sv
// Single-transfer Wishbone classic initiator for the SoC register bus.
// Takes one read/write command on a valid/ready port, runs one CYC/STB
// transfer (re-issuing on RTY up to MAX_RETRIES times with RETRY_GAP idle
// cycles in between, giving up after TIMEOUT_CYCLES silent cycles per
// attempt) and returns read data plus a status code on a valid/ready port.
// Ports:
//   p_clk   : clock, rising edge
//   p_reset : synchronous reset, active high
//   bus     : wb_soc_master_if.master (command, response, busy, Wishbone)
module wb_soc_master
    import wb_soc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_GAP      = 2
) (
    input  logic             p_clk,
    input  logic             p_reset,
    wb_soc_master_if.master  bus
);

    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int RTY_W = cnt_width(MAX_RETRIES);
    localparam int GAP_W = cnt_width(RETRY_GAP);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRY_GAP - 1);

    wb_mst_state_t       state_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                cyc_q;
    logic                stb_q;
    logic                we_q;
    logic                lock_q;       // LOCK_O as driven on the bus
    logic                lock_req_q;   // lock requested by the command, reused on retries
    logic [WB_ADR_W-1:0] adr_q;
    logic [WB_DAT_W-1:0] dat_q;
    logic [WB_SEL_W-1:0] sel_q;
    logic                rsp_valid_q;
    logic [WB_DAT_W-1:0] rsp_dat_q;
    wb_status_t          rsp_status_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [RTY_W-1:0]    retry_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;

    // Outcome of the current REQ cycle; only consulted while in REQ, which is
    // what makes ACK/ERR/RTY irrelevant in every other state.
    logic                xfer_done_d;
    logic                retry_d;
    wb_status_t          status_d;
    logic [WB_DAT_W-1:0] rsp_dat_d;

    always_comb begin
        xfer_done_d = 1'b0;
        retry_d     = 1'b0;
        status_d    = WB_OK;
        rsp_dat_d   = '0;
        // Priority ERR > RTY > ACK > timeout when several arrive together.
        if (bus.p_wb_ERR_I) begin
            xfer_done_d = 1'b1;
            status_d    = WB_ERR;
        end else if (bus.p_wb_RTY_I) begin
            if (retry_cnt_q < RTY_MAX) begin
                retry_d = 1'b1;
            end else begin
                xfer_done_d = 1'b1;
                status_d    = WB_RTY;
            end
        end else if (bus.p_wb_ACK_I) begin
            xfer_done_d = 1'b1;
            status_d    = WB_OK;
            rsp_dat_d   = we_q ? '0 : bus.p_wb_DAT_I;
        end else if (tmo_cnt_q == TMO_LAST) begin
            xfer_done_d = 1'b1;
            status_d    = WB_TMO;
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            lock_q       <= 1'b0;
            lock_req_q   <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= WB_OK;
            tmo_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            gap_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        state_q     <= REQ;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        adr_q       <= bus.cmd_adr;
                        dat_q       <= bus.cmd_dat;
                        sel_q       <= bus.cmd_sel;
                        we_q        <= bus.cmd_we;
                        lock_req_q  <= bus.cmd_lock;
                        lock_q      <= bus.cmd_lock;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        tmo_cnt_q   <= '0;
                        retry_cnt_q <= '0;
                    end
                end
                REQ: begin
                    if (xfer_done_d) begin
                        state_q      <= RESP;
                        cyc_q        <= 1'b0;
                        stb_q        <= 1'b0;
                        lock_q       <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= status_d;
                        rsp_dat_q    <= rsp_dat_d;
                    end else if (retry_d) begin
                        state_q     <= BACKOFF;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        lock_q      <= 1'b0;
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                        gap_cnt_q   <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                BACKOFF: begin
                    // CYC stays low for exactly RETRY_GAP cycles before re-issuing.
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q   <= REQ;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        lock_q    <= lock_req_q;
                        tmo_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_dat     = rsp_dat_q;
    assign bus.rsp_status  = rsp_status_q;
    assign bus.p_wb_ADR_O  = adr_q;
    assign bus.p_wb_DAT_O  = dat_q;
    assign bus.p_wb_SEL_O  = sel_q;
    assign bus.p_wb_WE_O   = we_q;
    assign bus.p_wb_CYC_O  = cyc_q;
    assign bus.p_wb_STB_O  = stb_q;
    assign bus.p_wb_LOCK_O = lock_q;

endmodule

// File: tb/tb_wb_soc_master.sv
// Directed testbench for wb_soc_master: a behavioural Wishbone slave with
// selectable response behaviour plus a bus monitor counting STB cycles,
// request phases, retry gaps and LOCK-outside-CYC cycles.
module tb_wb_soc_master;
    import wb_soc_pkg::*;

    localparam int SL_ACK    = 0;  // ACK after sl_wait STB cycles
    localparam int SL_RTY    = 1;  // RTY on every attempt
    localparam int SL_SILENT = 2;  // never responds
    localparam int SL_ERRACK = 3;  // ERR and ACK together

    logic p_clk   = 1'b0;
    logic p_reset = 1'b1;
    always #5 p_clk = ~p_clk;

    wb_soc_master_if bus();

    wb_soc_master #(
        .TIMEOUT_CYCLES(256),
        .MAX_RETRIES   (3),
        .RETRY_GAP     (2)
    ) dut (
        .p_clk  (p_clk),
        .p_reset(p_reset),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural slave
    int          sl_mode  = SL_ACK;
    int          sl_wait  = 0;
    logic [31:0] sl_rdata = 32'h0;
    int          sl_cnt   = 0;

    always @(posedge p_clk) sl_cnt <= (bus.p_wb_STB_O === 1'b1) ? sl_cnt + 1 : 0;

    always_comb begin
        bus.p_wb_ACK_I = 1'b0;
        bus.p_wb_ERR_I = 1'b0;
        bus.p_wb_RTY_I = 1'b0;
        bus.p_wb_DAT_I = sl_rdata;
        if (bus.p_wb_STB_O === 1'b1) begin
            case (sl_mode)
                SL_ACK:    bus.p_wb_ACK_I = (sl_cnt == sl_wait);
                SL_RTY:    bus.p_wb_RTY_I = 1'b1;
                SL_ERRACK: begin
                    bus.p_wb_ERR_I = 1'b1;
                    bus.p_wb_ACK_I = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // bus monitor, sampled on the falling edge
    int   mon_stb_cycles = 0;
    int   mon_phases     = 0;
    int   mon_gaps       = 0;
    int   mon_bad_gaps   = 0;
    int   mon_lock_bad   = 0;
    int   gap_cur        = 0;
    logic mon_prev_stb   = 1'b0;

    always @(negedge p_clk) begin
        if (bus.p_wb_STB_O === 1'b1) begin
            mon_stb_cycles <= mon_stb_cycles + 1;
            if (!mon_prev_stb) begin
                mon_phases <= mon_phases + 1;
                if (gap_cur > 0) begin
                    mon_gaps <= mon_gaps + 1;
                    if (gap_cur != 2) mon_bad_gaps <= mon_bad_gaps + 1;
                end
            end
            gap_cur <= 0;
        end else if (bus.busy === 1'b1 && bus.rsp_valid === 1'b0) begin
            gap_cur <= gap_cur + 1;
        end else begin
            gap_cur <= 0;
        end
        if (bus.p_wb_CYC_O === 1'b0 && bus.p_wb_LOCK_O === 1'b1) mon_lock_bad <= mon_lock_bad + 1;
        mon_prev_stb <= (bus.p_wb_STB_O === 1'b1);
    end

    // Present a command from a falling edge; returns at the falling edge of
    // the cycle after the handshake (cycle 1).
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic lock);
        bit ok;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        bus.cmd_lock  = lock;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge p_clk);
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cmd_handshake: cmd_ready=%b, required 1 within 20 cycles", bus.cmd_ready);
        end
        @(negedge p_clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for rsp_valid; cycles = falling edges advanced before it was seen.
    task automatic wait_rsp(input int max_cycles, output int cycles);
        cycles = 0;
        while (bus.rsp_valid !== 1'b1 && cycles < max_cycles) begin
            @(negedge p_clk);
            cycles++;
        end
        n_chk++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, cycles);
        end
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge p_clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge p_clk);
        @(negedge p_clk);
        p_reset = 1'b0;
        n_chk++;
        if ({bus.cmd_ready, bus.busy, bus.rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: {cmd_ready,busy,rsp_valid}=%b, required 100",
                     {bus.cmd_ready, bus.busy, bus.rsp_valid});
        end
        n_chk++;
        if ({bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_WE_O, bus.p_wb_LOCK_O} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_wb_ctrl: {CYC,STB,WE,LOCK}=%b, required 0000",
                     {bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_WE_O, bus.p_wb_LOCK_O});
        end
        n_chk++;
        if ({bus.p_wb_ADR_O, bus.p_wb_DAT_O, bus.p_wb_SEL_O} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_wb_data: ADR=%h DAT=%h SEL=%h, required all 0",
                     bus.p_wb_ADR_O, bus.p_wb_DAT_O, bus.p_wb_SEL_O);
        end
        n_chk++;
        if ({bus.rsp_dat, bus.rsp_status} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: rsp_dat=%h status=%0d, required 0/0", bus.rsp_dat, bus.rsp_status);
        end
    endtask

    task automatic test_write_ack();
        int base;
        sl_mode = SL_ACK;
        sl_wait = 0;
        base = mon_stb_cycles;
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        n_chk++;
        if ({bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_WE_O, bus.p_wb_LOCK_O} !== 4'b1110) begin
            n_fail++;
            $display("FAIL write_c1_ctrl: {CYC,STB,WE,LOCK}=%b, required 1110",
                     {bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_WE_O, bus.p_wb_LOCK_O});
        end
        n_chk++;
        if (bus.p_wb_ADR_O !== 32'h10 || bus.p_wb_DAT_O !== 32'hDEADBEEF || bus.p_wb_SEL_O !== 4'hF) begin
            n_fail++;
            $display("FAIL write_c1_bus: ADR=%h DAT=%h SEL=%h, required 00000010/deadbeef/f",
                     bus.p_wb_ADR_O, bus.p_wb_DAT_O, bus.p_wb_SEL_O);
        end
        @(negedge p_clk);
        n_chk++;
        if (bus.rsp_valid !== 1'b1 || bus.p_wb_STB_O !== 1'b0 || bus.p_wb_CYC_O !== 1'b0) begin
            n_fail++;
            $display("FAIL write_c2: rsp_valid=%b STB=%b CYC=%b, required 1/0/0",
                     bus.rsp_valid, bus.p_wb_STB_O, bus.p_wb_CYC_O);
        end
        n_chk++;
        if (bus.rsp_status !== WB_OK || bus.rsp_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL write_rsp: status=%0d dat=%h, required 0/00000000", bus.rsp_status, bus.rsp_dat);
        end
        n_chk++;
        if (mon_stb_cycles - base != 1) begin
            n_fail++;
            $display("FAIL write_stb_len: %0d STB cycles, required 1", mon_stb_cycles - base);
        end
        take_rsp();
        n_chk++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_after_rsp: cmd_ready=%b busy=%b rsp_valid=%b, required 1/0/0",
                     bus.cmd_ready, bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_read_wait();
        int base, cyc;
        sl_mode  = SL_ACK;
        sl_wait  = 3;
        sl_rdata = 32'h12345678;
        base = mon_stb_cycles;
        send_cmd(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        n_chk++;
        if (bus.p_wb_WE_O !== 1'b0 || bus.p_wb_ADR_O !== 32'h20) begin
            n_fail++;
            $display("FAIL read_c1: WE=%b ADR=%h, required 0/00000020", bus.p_wb_WE_O, bus.p_wb_ADR_O);
        end
        wait_rsp(50, cyc);
        n_chk++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL read_latency: rsp after %0d cycles past cycle 1, required 4", cyc);
        end
        n_chk++;
        if (mon_stb_cycles - base != 4) begin
            n_fail++;
            $display("FAIL read_stb_len: %0d STB cycles, required 4", mon_stb_cycles - base);
        end
        n_chk++;
        if (bus.rsp_dat !== 32'h12345678 || bus.rsp_status !== WB_OK) begin
            n_fail++;
            $display("FAIL read_rsp: dat=%h status=%0d, required 12345678/0", bus.rsp_dat, bus.rsp_status);
        end
        take_rsp();
    endtask

    task automatic test_retry();
        int b_stb, b_ph, b_gap, b_bad, b_lock, cyc;
        sl_mode  = SL_RTY;
        sl_rdata = 32'h5555AAAA;
        b_stb = mon_stb_cycles;
        b_ph = mon_phases;
        b_gap = mon_gaps;
        b_bad = mon_bad_gaps;
        b_lock = mon_lock_bad;
        send_cmd(1'b0, 32'h30, 32'h0, 4'h3, 1'b1);
        n_chk++;
        if (bus.p_wb_LOCK_O !== 1'b1) begin
            n_fail++;
            $display("FAIL retry_lock: LOCK=%b in first REQ, required 1", bus.p_wb_LOCK_O);
        end
        wait_rsp(100, cyc);
        n_chk++;
        if (cyc != 10) begin
            n_fail++;
            $display("FAIL retry_latency: rsp after %0d cycles past cycle 1, required 10", cyc);
        end
        n_chk++;
        if (mon_phases - b_ph != 4 || mon_stb_cycles - b_stb != 4) begin
            n_fail++;
            $display("FAIL retry_phases: %0d phases / %0d STB cycles, required 4/4",
                     mon_phases - b_ph, mon_stb_cycles - b_stb);
        end
        n_chk++;
        if (mon_gaps - b_gap != 3 || mon_bad_gaps - b_bad != 0) begin
            n_fail++;
            $display("FAIL retry_gaps: %0d gaps, %0d not 2 cycles long, required 3/0",
                     mon_gaps - b_gap, mon_bad_gaps - b_bad);
        end
        n_chk++;
        if (mon_lock_bad - b_lock != 0) begin
            n_fail++;
            $display("FAIL retry_lock_gap: LOCK high with CYC low for %0d cycles, required 0",
                     mon_lock_bad - b_lock);
        end
        n_chk++;
        if (bus.rsp_status !== WB_RTY || bus.rsp_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL retry_rsp: status=%0d dat=%h, required 2/00000000", bus.rsp_status, bus.rsp_dat);
        end
        take_rsp();
    endtask

    task automatic test_timeout();
        int base, cyc;
        sl_mode = SL_SILENT;
        base = mon_stb_cycles;
        send_cmd(1'b1, 32'h40, 32'h0BADF00D, 4'h1, 1'b0);
        wait_rsp(400, cyc);
        n_chk++;
        if (mon_stb_cycles - base != 256) begin
            n_fail++;
            $display("FAIL tmo_stb_len: %0d STB cycles, required 256", mon_stb_cycles - base);
        end
        n_chk++;
        if (bus.rsp_status !== WB_TMO || bus.rsp_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL tmo_rsp: status=%0d dat=%h, required 3/00000000", bus.rsp_status, bus.rsp_dat);
        end
        take_rsp();
    endtask

    task automatic test_err_ack();
        int cyc;
        sl_mode  = SL_ERRACK;
        sl_rdata = 32'hCAFEF00D;
        send_cmd(1'b0, 32'h50, 32'h0, 4'hF, 1'b0);
        wait_rsp(20, cyc);
        n_chk++;
        if (cyc != 1) begin
            n_fail++;
            $display("FAIL err_latency: rsp after %0d cycles past cycle 1, required 1", cyc);
        end
        n_chk++;
        if (bus.rsp_status !== WB_ERR || bus.rsp_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL err_rsp: status=%0d dat=%h, required 1/00000000", bus.rsp_status, bus.rsp_dat);
        end
        take_rsp();
    endtask

    task automatic test_rsp_hold();
        int cyc, base;
        sl_mode  = SL_ACK;
        sl_wait  = 0;
        sl_rdata = 32'hA5A55A5A;
        send_cmd(1'b0, 32'h60, 32'h0, 4'hF, 1'b0);
        wait_rsp(20, cyc);
        // A competing command must be ignored while the response is pending.
        bus.cmd_we    = 1'b1;
        bus.cmd_adr   = 32'h99;
        bus.cmd_valid = 1'b1;
        base = mon_stb_cycles;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'hA5A55A5A || bus.rsp_status !== WB_OK
                || bus.cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b dat=%h status=%0d cmd_ready=%b, required 1/a5a55a5a/0/0",
                         i, bus.rsp_valid, bus.rsp_dat, bus.rsp_status, bus.cmd_ready);
            end
            @(negedge p_clk);
        end
        n_chk++;
        if (mon_stb_cycles - base != 0) begin
            n_fail++;
            $display("FAIL hold_no_stb: %0d STB cycles while response pending, required 0",
                     mon_stb_cycles - base);
        end
        bus.cmd_valid = 1'b0;
        take_rsp();
        n_chk++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: cmd_ready=%b, required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        sl_mode = SL_SILENT;
        send_cmd(1'b1, 32'h70, 32'h11112222, 4'hF, 1'b1);
        repeat (3) @(negedge p_clk);
        n_chk++;
        if (bus.p_wb_STB_O !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: STB=%b before reset, required 1", bus.p_wb_STB_O);
        end
        p_reset = 1'b1;
        @(negedge p_clk);
        p_reset = 1'b0;
        n_chk++;
        if ({bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_LOCK_O, bus.busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_bus: {CYC,STB,LOCK,busy}=%b, required 0000",
                     {bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_LOCK_O, bus.busy});
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_idle%0d: rsp_valid=%b cmd_ready=%b, required 0/1",
                         i, bus.rsp_valid, bus.cmd_ready);
            end
            @(negedge p_clk);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        sl_mode = SL_ACK;
        sl_wait = 0;
        send_cmd(1'b1, 32'h80, 32'h00000001, 4'h1, 1'b0);
        wait_rsp(20, cyc);
        take_rsp();
        send_cmd(1'b1, 32'h84, 32'h00000002, 4'h2, 1'b0);
        n_chk++;
        if (bus.p_wb_ADR_O !== 32'h84 || bus.p_wb_DAT_O !== 32'h2 || bus.p_wb_SEL_O !== 4'h2
            || bus.p_wb_STB_O !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: ADR=%h DAT=%h SEL=%h STB=%b, required 00000084/00000002/2/1",
                     bus.p_wb_ADR_O, bus.p_wb_DAT_O, bus.p_wb_SEL_O, bus.p_wb_STB_O);
        end
        wait_rsp(20, cyc);
        n_chk++;
        if (bus.rsp_status !== WB_OK) begin
            n_fail++;
            $display("FAIL b2b_rsp: status=%0d, required 0", bus.rsp_status);
        end
        take_rsp();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h0;
        bus.cmd_lock  = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write_ack();
        test_read_wait();
        test_retry();
        test_timeout();
        test_err_ack();
        test_rsp_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
